// File: rtl/embertrail_dmem_pkg.sv
// Shared types and constants for the Embertrail data-memory controller.
// The optional feature macro EMBERTRAIL_DMEM_PERF_CNT_EN is handled in embertrail_dmem_ctrl.sv.
package embertrail_dmem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } dmem_state_e;

    localparam logic DMEM_RD = 1'b0;
    localparam logic DMEM_WR = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/embertrail_dmem_ctrl_if.sv
// Core-side handshake and bank-side bus of the Embertrail data-memory controller.
// master = core plus banks, slave = the controller.
interface embertrail_dmem_ctrl_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned NUM_BANKS = 2
);

    logic                 iReq;
    logic                 iWrite;
    logic [ADDR_W-1:0]    iAddr;
    logic [DATA_W-1:0]    iWData;
    logic [DATA_W-1:0]    oRData;
    logic                 oReady;
    logic                 oBusy;
    logic                 oBankErr;
    logic [ADDR_W-1:0]    oDataAddrBus;
    logic [DATA_W-1:0]    oDataWrBus;
    logic [DATA_W-1:0]    iDataDataBus;
    logic [NUM_BANKS-1:0] oDataMemRW;
    logic [NUM_BANKS-1:0] oDataBusEn;

    modport master (
        output iReq, iWrite, iAddr, iWData, iDataDataBus,
        input  oRData, oReady, oBusy, oBankErr, oDataAddrBus, oDataWrBus, oDataMemRW, oDataBusEn
    );

    modport slave (
        input  iReq, iWrite, iAddr, iWData, iDataDataBus,
        output oRData, oReady, oBusy, oBankErr, oDataAddrBus, oDataWrBus, oDataMemRW, oDataBusEn
    );

endinterface

// File: rtl/embertrail_bank_decode.sv
// Combinational bank decode: index field to one-hot bank select plus unmapped flag.
module embertrail_bank_decode
    import embertrail_dmem_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 2,
    localparam int unsigned IW = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1
) (
    input  logic [IW-1:0]        bank_field_i,
    output logic [NUM_BANKS-1:0] bank_sel_o,
    output logic                 unmapped_o
);

    logic [31:0] idx_ext;

    always_comb begin
        idx_ext    = 32'(bank_field_i);
        bank_sel_o = '0;
        // Non-power-of-two bank counts leave the top index codes unmapped.
        unmapped_o = (idx_ext >= NUM_BANKS);
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            bank_sel_o[b] = (idx_ext == b);
        end
    end

endmodule

// File: rtl/embertrail_dmem_ctrl.sv
// Embertrail data-memory access controller: bank decode, wait states, request/ready handshake.
// Optional saturating read/write counters under EMBERTRAIL_DMEM_PERF_CNT_EN.
module embertrail_dmem_ctrl
    import embertrail_dmem_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned NUM_BANKS   = 2,
    parameter int unsigned BANK_LSB    = 16,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  iClock,
    input  logic                  iReset,
    embertrail_dmem_ctrl_if.slave bus
`ifdef EMBERTRAIL_DMEM_PERF_CNT_EN
    ,
    output logic [15:0]           oRdCount,
    output logic [15:0]           oWrCount
`endif
);

    localparam int unsigned IW = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1;
    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    dmem_state_e          state_q;
    logic [3:0]           cnt_q;
    logic                 write_q;
    logic                 err_q;
    logic                 ready_q;
    logic                 busy_q;
    logic [DATA_W-1:0]    rdata_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wbus_q;
    logic [NUM_BANKS-1:0] en_q;
    logic [NUM_BANKS-1:0] rw_q;

    logic [NUM_BANKS-1:0] bank_sel;
    logic                 unmapped;

    embertrail_bank_decode #(
        .NUM_BANKS (NUM_BANKS)
    ) u_bank_decode (
        .bank_field_i (bus.iAddr[BANK_LSB +: IW]),
        .bank_sel_o   (bank_sel),
        .unmapped_o   (unmapped)
    );

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= DMEM_RD;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wbus_q  <= '0;
            en_q    <= '0;
            rw_q    <= '0;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.iReq) begin
                        busy_q  <= 1'b1;
                        write_q <= bus.iWrite;
                        err_q   <= unmapped;
                        if (unmapped) begin
                            // No bank is touched; respond with the error at once.
                            state_q <= StResp;
                            ready_q <= 1'b1;
                            if (bus.iWrite == DMEM_RD) begin
                                rdata_q <= '0;
                            end
                        end else begin
                            state_q <= StAccess;
                            cnt_q   <= WaitInit;
                            addr_q  <= bus.iAddr;
                            wbus_q  <= bus.iWData;
                            en_q    <= bank_sel;
                            rw_q    <= {NUM_BANKS{bus.iWrite}} & bank_sel;
                        end
                    end
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StResp;
                        ready_q <= 1'b1;
                        en_q    <= '0;
                        if (write_q == DMEM_RD) begin
                            rdata_q <= bus.iDataDataBus;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.oRData       = rdata_q;
    assign bus.oReady       = ready_q;
    assign bus.oBusy        = busy_q;
    assign bus.oBankErr     = err_q;
    assign bus.oDataAddrBus = addr_q;
    assign bus.oDataWrBus   = wbus_q;
    assign bus.oDataMemRW   = rw_q;
    assign bus.oDataBusEn   = en_q;

`ifdef EMBERTRAIL_DMEM_PERF_CNT_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (state_q == StResp && !err_q) begin
            if (write_q == DMEM_WR) begin
                if (wr_cnt_q != 16'hFFFF) begin
                    wr_cnt_q <= wr_cnt_q + 16'd1;
                end
            end else if (rd_cnt_q != 16'hFFFF) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign oRdCount = rd_cnt_q;
    assign oWrCount = wr_cnt_q;
`endif

endmodule

// File: tb/tb_embertrail_dmem_ctrl.sv
// Directed bench for embertrail_dmem_ctrl: default, 3-bank and zero-wait instances.
module tb_embertrail_dmem_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    embertrail_dmem_ctrl_if #(.DATA_W(32), .ADDR_W(32), .NUM_BANKS(2)) if_a ();
    embertrail_dmem_ctrl_if #(.DATA_W(32), .ADDR_W(32), .NUM_BANKS(3)) if_b ();
    embertrail_dmem_ctrl_if #(.DATA_W(32), .ADDR_W(32), .NUM_BANKS(2)) if_c ();

`ifdef EMBERTRAIL_DMEM_PERF_CNT_EN
    logic [15:0] a_rd_cnt, a_wr_cnt, b_rd_cnt, b_wr_cnt, c_rd_cnt, c_wr_cnt;
`endif

    embertrail_dmem_ctrl #(
        .NUM_BANKS (2), .BANK_LSB (16), .WAIT_CYCLES (1)
    ) u_dut_a (
        .iClock (clk), .iReset (rst), .bus (if_a)
`ifdef EMBERTRAIL_DMEM_PERF_CNT_EN
        , .oRdCount (a_rd_cnt), .oWrCount (a_wr_cnt)
`endif
    );

    embertrail_dmem_ctrl #(
        .NUM_BANKS (3), .BANK_LSB (16), .WAIT_CYCLES (1)
    ) u_dut_b (
        .iClock (clk), .iReset (rst), .bus (if_b)
`ifdef EMBERTRAIL_DMEM_PERF_CNT_EN
        , .oRdCount (b_rd_cnt), .oWrCount (b_wr_cnt)
`endif
    );

    embertrail_dmem_ctrl #(
        .NUM_BANKS (2), .BANK_LSB (16), .WAIT_CYCLES (0)
    ) u_dut_c (
        .iClock (clk), .iReset (rst), .bus (if_c)
`ifdef EMBERTRAIL_DMEM_PERF_CNT_EN
        , .oRdCount (c_rd_cnt), .oWrCount (c_wr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access on the 3-bank instance, ending back in IDLE.
    task automatic b_access(input logic wr, input logic [31:0] addr);
        if_b.iWrite = wr;
        if_b.iAddr  = addr;
        if_b.iWData = addr ^ 32'h5A5A_5A5A;
        if_b.iReq   = 1'b1;
        tick();
        if_b.iReq = 1'b0;
        repeat (3) tick();
    endtask

    int ready_seen;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        if_a.iReq = 1'b0; if_a.iWrite = 1'b0; if_a.iAddr = '0; if_a.iWData = '0;
        if_a.iDataDataBus = '0;
        if_b.iReq = 1'b0; if_b.iWrite = 1'b0; if_b.iAddr = '0; if_b.iWData = '0;
        if_b.iDataDataBus = '0;
        if_c.iReq = 1'b0; if_c.iWrite = 1'b0; if_c.iAddr = '0; if_c.iWData = '0;
        if_c.iDataDataBus = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check_eq("rst_rdata", 64'(if_a.oRData), 64'h0);
        check_eq("rst_ready", 64'(if_a.oReady), 64'h0);
        check_eq("rst_busy", 64'(if_a.oBusy), 64'h0);
        check_eq("rst_err", 64'(if_a.oBankErr), 64'h0);
        check_eq("rst_addrbus", 64'(if_a.oDataAddrBus), 64'h0);
        check_eq("rst_wrbus", 64'(if_a.oDataWrBus), 64'h0);
        check_eq("rst_memrw", 64'(if_a.oDataMemRW), 64'h0);
        check_eq("rst_busen", 64'(if_a.oDataBusEn), 64'h0);
        rst = 1'b0;
        tick();

        // Read from bank 1
        if_a.iAddr = 32'h0001_0040; if_a.iWrite = 1'b0; if_a.iReq = 1'b1;
        if_a.iDataDataBus = 32'hDEAD_BEEF;
        tick();
        if_a.iReq = 1'b0;
        check_eq("rd_en_c1", 64'(if_a.oDataBusEn), 64'h2);
        check_eq("rd_rw_c1", 64'(if_a.oDataMemRW), 64'h0);
        check_eq("rd_busy_c1", 64'(if_a.oBusy), 64'h1);
        check_eq("rd_ready_c1", 64'(if_a.oReady), 64'h0);
        check_eq("rd_addr_c1", 64'(if_a.oDataAddrBus), 64'h0001_0040);
        tick();
        check_eq("rd_en_c2", 64'(if_a.oDataBusEn), 64'h2);
        check_eq("rd_ready_c2", 64'(if_a.oReady), 64'h0);
        tick();
        check_eq("rd_en_c3", 64'(if_a.oDataBusEn), 64'h0);
        check_eq("rd_ready_c3", 64'(if_a.oReady), 64'h1);
        check_eq("rd_rdata", 64'(if_a.oRData), 64'hDEAD_BEEF);
        check_eq("rd_err", 64'(if_a.oBankErr), 64'h0);
        tick();
        check_eq("rd_ready_c4", 64'(if_a.oReady), 64'h0);
        check_eq("rd_busy_c4", 64'(if_a.oBusy), 64'h0);
        check_eq("rd_addr_hold", 64'(if_a.oDataAddrBus), 64'h0001_0040);

        // Write to bank 0
        if_a.iAddr = 32'h0000_0010; if_a.iWrite = 1'b1; if_a.iWData = 32'h1234_5678;
        if_a.iDataDataBus = 32'hCAFE_F00D; if_a.iReq = 1'b1;
        tick();
        if_a.iReq = 1'b0;
        check_eq("wr_en_c1", 64'(if_a.oDataBusEn), 64'h1);
        check_eq("wr_rw_c1", 64'(if_a.oDataMemRW), 64'h1);
        check_eq("wr_bus_c1", 64'(if_a.oDataWrBus), 64'h1234_5678);
        tick();
        check_eq("wr_en_c2", 64'(if_a.oDataBusEn), 64'h1);
        check_eq("wr_rw_c2", 64'(if_a.oDataMemRW), 64'h1);
        tick();
        check_eq("wr_ready_c3", 64'(if_a.oReady), 64'h1);
        check_eq("wr_en_c3", 64'(if_a.oDataBusEn), 64'h0);
        check_eq("wr_rdata_kept", 64'(if_a.oRData), 64'hDEAD_BEEF);
        tick();
        check_eq("wr_busy_c4", 64'(if_a.oBusy), 64'h0);

        // 3-bank instance: mapped read of bank 2, then unmapped read of index 3
        if_b.iDataDataBus = 32'hA5A5_0001;
        b_access(1'b0, 32'h0002_0000);
        check_eq("nb3_rdata", 64'(if_b.oRData), 64'hA5A5_0001);
        if_b.iAddr = 32'h0003_0000; if_b.iWrite = 1'b0; if_b.iReq = 1'b1;
        tick();
        if_b.iReq = 1'b0;
        check_eq("unm_en", 64'(if_b.oDataBusEn), 64'h0);
        check_eq("unm_ready", 64'(if_b.oReady), 64'h1);
        check_eq("unm_err", 64'(if_b.oBankErr), 64'h1);
        check_eq("unm_rdata", 64'(if_b.oRData), 64'h0);
        check_eq("unm_busy", 64'(if_b.oBusy), 64'h1);
        tick();
        check_eq("unm_ready_c2", 64'(if_b.oReady), 64'h0);
        check_eq("unm_busy_c2", 64'(if_b.oBusy), 64'h0);
        check_eq("unm_err_hold", 64'(if_b.oBankErr), 64'h1);
        if_b.iAddr = 32'h0001_0000; if_b.iReq = 1'b1;
        tick();
        if_b.iReq = 1'b0;
        check_eq("err_cleared", 64'(if_b.oBankErr), 64'h0);
        check_eq("nb3_en_b1", 64'(if_b.oDataBusEn), 64'h2);
        repeat (3) tick();

        // Zero-wait instance with iReq held high
        if_c.iAddr = 32'h0000_0000; if_c.iWrite = 1'b0; if_c.iDataDataBus = 32'h0BAD_CAFE;
        if_c.iReq = 1'b1;
        tick();
        check_eq("w0_en_c1", 64'(if_c.oDataBusEn), 64'h1);
        check_eq("w0_ready_c1", 64'(if_c.oReady), 64'h0);
        tick();
        check_eq("w0_en_c2", 64'(if_c.oDataBusEn), 64'h0);
        check_eq("w0_ready_c2", 64'(if_c.oReady), 64'h1);
        check_eq("w0_rdata", 64'(if_c.oRData), 64'h0BAD_CAFE);
        tick();
        check_eq("w0_busy_c3", 64'(if_c.oBusy), 64'h0);
        check_eq("w0_en_c3", 64'(if_c.oDataBusEn), 64'h0);
        tick();
        check_eq("w0_en_c4", 64'(if_c.oDataBusEn), 64'h1);
        check_eq("w0_busy_c4", 64'(if_c.oBusy), 64'h1);
        if_c.iReq = 1'b0;
        repeat (3) tick();

        // Reset in the second ACCESS cycle abandons the access
        if_a.iAddr = 32'h0001_0000; if_a.iWrite = 1'b0; if_a.iReq = 1'b1;
        tick();
        if_a.iReq = 1'b0;
        check_eq("rst_acc_en_c1", 64'(if_a.oDataBusEn), 64'h2);
        tick();
        rst = 1'b1;
        #1;
        check_eq("rst_acc_en", 64'(if_a.oDataBusEn), 64'h0);
        check_eq("rst_acc_busy", 64'(if_a.oBusy), 64'h0);
        check_eq("rst_acc_rdata", 64'(if_a.oRData), 64'h0);
        #2;
        rst = 1'b0;
        ready_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (if_a.oReady) ready_seen++;
        end
        check_eq("rst_acc_no_ready", 64'(ready_seen), 64'h0);
        check_eq("rst_acc_idle", 64'(if_a.oBusy), 64'h0);

        // Counter run on the 3-bank instance (counters cleared by the reset above)
        b_access(1'b0, 32'h0000_0000);
        b_access(1'b0, 32'h0001_0000);
        b_access(1'b0, 32'h0002_0000);
        b_access(1'b1, 32'h0000_0004);
        b_access(1'b1, 32'h0001_0008);
        b_access(1'b0, 32'h0003_0000);
        check_eq("cnt_last_err", 64'(if_b.oBankErr), 64'h1);
`ifdef EMBERTRAIL_DMEM_PERF_CNT_EN
        check_eq("perf_rd", 64'(b_rd_cnt), 64'd3);
        check_eq("perf_wr", 64'(b_wr_cnt), 64'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
